// File: rtl/controlpath_pkg.sv
// Shared types and constants for the multi-cycle fetch/execute sequencer.
package controlpath_pkg;

    // Encoding is visible on the debug state port, so values are pinned.
    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/controlpath_seq_pc_unit.sv
// PC/NPC registers with next-address selection and halt-address compare.
module pc_unit
    import controlpath_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        commit_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o,
    output logic        halt_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] redirect;

    always_comb begin
        pc_d     = pc_q;
        npc_d    = npc_q;
        redirect = branch_valid_i ? branch_target_i : npc_q;
        if (commit_i) begin
            if (DELAY_SLOT) begin
                // Delay slot: the instruction after the branch runs before the target.
                pc_d  = npc_q;
                npc_d = branch_valid_i ? branch_target_i : npc_q + 32'(INSTR_BYTES);
            end else begin
                pc_d  = redirect;
                npc_d = redirect + 32'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q  <= RESET_VECTOR;
            npc_q <= RESET_VECTOR + 32'(INSTR_BYTES);
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc_o   = pc_q;
    assign halt_o = commit_i && (pc_d == HALT_ADDR);

endmodule

// File: rtl/controlpath_seq.sv
// Fetch/execute sequencer: owns the state machine, instruction register and halt detection.
module controlpath_seq
    import controlpath_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] ir,
    output logic        exec,
    input  logic        data_stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        active,
    output logic        finish,
    output logic [1:0]  state
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc;
    logic        commit;
    logic        halt_next;

    assign commit = (state_q == EXEC) && !data_stall;

    pc_unit #(
        .RESET_VECTOR (RESET_VECTOR),
        .HALT_ADDR    (HALT_ADDR),
        .DELAY_SLOT   (DELAY_SLOT)
    ) u_pc_unit (
        .clk_i           (clk),
        .rst_ni          (reset),
        .commit_i        (commit),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
        .pc_o            (pc),
        .halt_o          (halt_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RST;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            RST:   state_d = FETCH;
            FETCH: begin
                if (!instr_waitrequest) begin
                    ir_d    = instr_readdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    state_d = halt_next ? HALT : FETCH;
                end
            end
            HALT:  state_d = HALT;
            default: state_d = RST;
        endcase
    end

    // All outputs decode registered state only, so none follow input glitches.
    always_comb begin
        instr_read    = (state_q == FETCH);
        exec          = (state_q == EXEC);
        active        = (state_q == FETCH) || (state_q == EXEC);
        finish        = (state_q == HALT);
        instr_address = (state_q == HALT) ? HALT_ADDR : pc;
        ir            = ir_q;
        state         = state_q;
    end

endmodule

// File: tb/tb_controlpath_seq.sv
// Bench for controlpath_seq: directed scenarios plus a randomized run against a reference model.
module tb_controlpath_seq;

    localparam logic [31:0] RV = 32'hBFC0_0000;
    // Status vector layout: {state[1:0], instr_read, exec, active, finish}
    localparam logic [5:0] S_RST   = 6'b00_0_0_0_0;
    localparam logic [5:0] S_FETCH = 6'b01_1_0_1_0;
    localparam logic [5:0] S_EXEC  = 6'b10_0_1_1_0;
    localparam logic [5:0] S_HALT  = 6'b11_0_0_0_1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0, stall = 1'b0, bv = 1'b0;
    logic [31:0] rd = '0, bt = '0;

    logic [31:0] addr0, addr1, ir0, ir1;
    logic        rdq0, rdq1, ex0, ex1, ac0, ac1, fi0, fi1;
    logic [1:0]  st0, st1;
    logic [5:0]  sv0, sv1;
    assign sv0 = {st0, rdq0, ex0, ac0, fi0};
    assign sv1 = {st1, rdq1, ex1, ac1, fi1};

    int errors = 0;
    int checks = 0;

    // Reference model, index 0 = no delay slot, 1 = delay slot.
    int          m_mode[2];
    logic [31:0] m_pc[2], m_npc[2], m_ir[2];

    always #5 clk = ~clk;

    controlpath_seq #(.DELAY_SLOT(1'b1)) u_ds1 (
        .clk(clk), .reset(reset), .instr_address(addr1), .instr_read(rdq1),
        .instr_waitrequest(wr), .instr_readdata(rd), .ir(ir1), .exec(ex1),
        .data_stall(stall), .branch_valid(bv), .branch_target(bt),
        .active(ac1), .finish(fi1), .state(st1)
    );

    controlpath_seq #(.DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .reset(reset), .instr_address(addr0), .instr_read(rdq0),
        .instr_waitrequest(wr), .instr_readdata(rd), .ir(ir0), .exec(ex0),
        .data_stall(stall), .branch_valid(bv), .branch_target(bt),
        .active(ac0), .finish(fi0), .state(st0)
    );

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_pc[k]   = RV;
            m_npc[k]  = RV + 32'd4;
            m_ir[k]   = '0;
        end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] np, nn;
            case (m_mode[k])
                0: m_mode[k] = 1;
                1: if (!wr) begin m_ir[k] = rd; m_mode[k] = 2; end
                2: if (!stall) begin
                    if (k == 1) begin
                        np = m_npc[k];
                        nn = bv ? bt : m_npc[k] + 32'd4;
                    end else begin
                        np = bv ? bt : m_npc[k];
                        nn = np + 32'd4;
                    end
                    m_pc[k]   = np;
                    m_npc[k]  = nn;
                    m_mode[k] = (np == 32'd0) ? 3 : 1;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; wr = 1'b0; stall = 1'b0; bv = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sv1 !== S_RST) begin errors++; $display("FAIL reset_status: got %b want %b", sv1, S_RST); end
        checks++; if (sv0 !== S_RST) begin errors++; $display("FAIL reset_status_ds0: got %b want %b", sv0, S_RST); end
        checks++; if (addr1 !== RV) begin errors++; $display("FAIL reset_addr: got %h want %h", addr1, RV); end
        checks++; if (ir1 !== 32'd0) begin errors++; $display("FAIL reset_ir: got %h want 0", ir1); end
    endtask

    task automatic test_sequence(output logic [31:0] last_ir);
        logic [31:0] r;
        r = $urandom; rd = r;
        tick();
        checks++; if ({sv1, addr1} !== {S_FETCH, RV}) begin errors++; $display("FAIL seq_fetch0: got %b/%h want %b/%h", sv1, addr1, S_FETCH, RV); end
        tick();
        checks++; if ({sv1, ir1} !== {S_EXEC, r}) begin errors++; $display("FAIL seq_exec0: got %b/%h want %b/%h", sv1, ir1, S_EXEC, r); end
        rd = $urandom;
        tick();
        checks++; if ({sv1, addr1} !== {S_FETCH, RV + 32'd4}) begin errors++; $display("FAIL seq_fetch4: got %b/%h want %b/%h", sv1, addr1, S_FETCH, RV + 32'd4); end
        last_ir = r;
    endtask

    task automatic test_waitrequest(input logic [31:0] prev_ir);
        logic [31:0] r2;
        wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd = $urandom;
            tick();
            checks++;
            if ({sv1, addr1, ir1} !== {S_FETCH, RV + 32'd4, prev_ir}) begin
                errors++; $display("FAIL wait_hold[%0d]: got %b/%h/%h want %b/%h/%h", i, sv1, addr1, ir1, S_FETCH, RV + 32'd4, prev_ir);
            end
        end
        wr = 1'b0; r2 = $urandom; rd = r2;
        tick();
        checks++; if ({sv1, ir1} !== {S_EXEC, r2}) begin errors++; $display("FAIL wait_accept: got %b/%h want %b/%h", sv1, ir1, S_EXEC, r2); end
        tick();
        checks++; if ({sv1, addr1} !== {S_FETCH, RV + 32'd8}) begin errors++; $display("FAIL wait_next: got %b/%h want %b/%h", sv1, addr1, S_FETCH, RV + 32'd8); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({sv1, addr1} !== {S_EXEC, RV}) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h want %b/%h", i, sv1, addr1, S_EXEC, RV); end
        end
        stall = 1'b0;
        tick();
        checks++; if ({sv1, addr1} !== {S_FETCH, RV + 32'd4}) begin errors++; $display("FAIL stall_commit: got %b/%h want %b/%h", sv1, addr1, S_FETCH, RV + 32'd4); end
        tick(); tick();
        checks++; if (addr1 !== RV + 32'd8) begin errors++; $display("FAIL stall_single_commit: got %h want %h", addr1, RV + 32'd8); end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (6) tick();
        bv = 1'b1; bt = RV + 32'h100;
        tick();
        bv = 1'b1; bt = 32'h1234_5670; // present in FETCH, must be ignored
        checks++; if ({sv1, addr1} !== {S_FETCH, RV + 32'hC}) begin errors++; $display("FAIL br_slot_ds1: got %b/%h want %b/%h", sv1, addr1, S_FETCH, RV + 32'hC); end
        checks++; if ({sv0, addr0} !== {S_FETCH, RV + 32'h100}) begin errors++; $display("FAIL br_target_ds0: got %b/%h want %b/%h", sv0, addr0, S_FETCH, RV + 32'h100); end
        tick();
        bv = 1'b0;
        tick();
        checks++; if ({sv1, addr1} !== {S_FETCH, RV + 32'h100}) begin errors++; $display("FAIL br_target_ds1: got %b/%h want %b/%h", sv1, addr1, S_FETCH, RV + 32'h100); end
        checks++; if ({sv0, addr0} !== {S_FETCH, RV + 32'h104}) begin errors++; $display("FAIL br_next_ds0: got %b/%h want %b/%h", sv0, addr0, S_FETCH, RV + 32'h104); end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (10) tick();
        bv = 1'b1; bt = 32'd0;
        tick();
        bv = 1'b0;
        checks++; if ({sv1, addr1} !== {S_FETCH, RV + 32'h14}) begin errors++; $display("FAIL halt_slot_ds1: got %b/%h want %b/%h", sv1, addr1, S_FETCH, RV + 32'h14); end
        checks++; if ({sv0, addr0} !== {S_HALT, 32'd0}) begin errors++; $display("FAIL halt_ds0: got %b/%h want %b/0", sv0, addr0, S_HALT); end
        tick();
        checks++; if (sv1 !== S_EXEC) begin errors++; $display("FAIL halt_slot_exec: got %b want %b", sv1, S_EXEC); end
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({sv1, addr1, sv0, addr0} !== {S_HALT, 32'd0, S_HALT, 32'd0}) begin
                errors++; $display("FAIL halt_hold[%0d]: got %b/%h %b/%h want %b/0", i, sv1, addr1, sv0, addr0, S_HALT);
            end
            wr = $urandom_range(0, 1); stall = $urandom_range(0, 1);
            bv = $urandom_range(0, 1); bt = $urandom;
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(); tick();
        bv = 1'b1; bt = 32'hFFFF_FFF8;
        tick();
        bv = 1'b0;
        checks++; if (addr0 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a: got %h want fffffff8", addr0); end
        tick(); tick();
        checks++; if ({sv0, addr0} !== {S_FETCH, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_b: got %b/%h want %b/fffffffc", sv0, addr0, S_FETCH); end
        tick(); tick();
        checks++; if ({sv0, addr0} !== {S_HALT, 32'd0}) begin errors++; $display("FAIL wrap_halt: got %b/%h want %b/0", sv0, addr0, S_HALT); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        rd = $urandom;
        tick(); tick(); tick();
        wr = 1'b1;
        tick();
        checks++; if ({sv1, addr1} !== {S_FETCH, RV + 32'd4}) begin errors++; $display("FAIL abort_pre: got %b/%h want %b/%h", sv1, addr1, S_FETCH, RV + 32'd4); end
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if ({sv1, addr1, ir1} !== {S_RST, RV, 32'd0}) begin errors++; $display("FAIL abort_now: got %b/%h/%h want %b/%h/0", sv1, addr1, ir1, S_RST, RV); end
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1; wr = 1'b0;
        tick();
        checks++; if ({sv1, addr1, ir1} !== {S_FETCH, RV, 32'd0}) begin errors++; $display("FAIL abort_restart: got %b/%h/%h want %b/%h/0", sv1, addr1, ir1, S_FETCH, RV); end
    endtask

    task automatic test_random();
        logic [5:0]  esv;
        logic [31:0] eaddr;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0 || (m_mode[0] == 3 && m_mode[1] == 3)) do_reset();
            wr    = ($urandom_range(0, 2) == 0);
            stall = ($urandom_range(0, 2) == 0);
            bv    = ($urandom_range(0, 3) == 0);
            rd    = $urandom;
            case ($urandom_range(0, 7))
                0:       bt = 32'd0;
                1, 2:    bt = 32'hFFFF_FFF8;
                3:       bt = RV + 32'h100;
                default: bt = $urandom;
            endcase
            for (int k = 0; k < 2; k++) begin
                esv   = {m_mode[k][1:0], m_mode[k] == 1, m_mode[k] == 2,
                         m_mode[k] == 1 || m_mode[k] == 2, m_mode[k] == 3};
                eaddr = (m_mode[k] == 3) ? 32'd0 : m_pc[k];
                checks++;
                if (k == 1 ? ({sv1, addr1, ir1} !== {esv, eaddr, m_ir[k]})
                           : ({sv0, addr0, ir0} !== {esv, eaddr, m_ir[k]})) begin
                    errors++;
                    $display("FAIL rand[%0d] ds%0d: got %b/%h/%h want %b/%h/%h", n, k,
                             k == 1 ? sv1 : sv0, k == 1 ? addr1 : addr0, k == 1 ? ir1 : ir0,
                             esv, eaddr, m_ir[k]);
                end
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] last_ir;
        test_reset();
        test_sequence(last_ir);
        test_waitrequest(last_ir);
        test_stall();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
